// File: rtl/main_mem_fu_if.sv
// Purpose: bundles the main-memory and register-file handshake lanes of main_mem_fu.
// Ports: master = functional unit side (drives requests and addresses/data), slave = memory/regfile side.
// Each lane carries a level request that is held until its ack is seen high; data is valid alongside the ack.
interface main_mem_fu_if #(
  parameter int data_width        = 32,
  parameter int addr_size         = 16,
  parameter int reg_set_idx_width = 3
);
  // main memory, lanes 1/2
  logic [addr_size-1:0]         addr1_o, addr2_o;
  logic                         read_en1_o, read_en2_o;
  logic [data_width-1:0]        r_data1_i, r_data2_i;
  logic                         read_ack1_i, read_ack2_i;
  logic                         write_en1_o, write_en2_o;
  logic [data_width-1:0]        w_data1_o, w_data2_o;
  logic                         write_ack1_i, write_ack2_i;
  // register file, lanes 1/2
  logic                         reg_read1_o, reg_read2_o;
  logic                         reg_write1_o, reg_write2_o;
  logic [reg_set_idx_width-1:0] reg_set1_idx_o, reg_set2_idx_o;
  logic [data_width-1:0]        reg_data1_o, reg_data2_o;
  logic [data_width-1:0]        reg_data1_i, reg_data2_i;
  logic                         reg_ack1_i, reg_ack2_i;

  modport master (
    output addr1_o, addr2_o, read_en1_o, read_en2_o, write_en1_o, write_en2_o,
    output w_data1_o, w_data2_o, reg_read1_o, reg_read2_o, reg_write1_o, reg_write2_o,
    output reg_set1_idx_o, reg_set2_idx_o, reg_data1_o, reg_data2_o,
    input  r_data1_i, r_data2_i, read_ack1_i, read_ack2_i, write_ack1_i, write_ack2_i,
    input  reg_data1_i, reg_data2_i, reg_ack1_i, reg_ack2_i
  );

  modport slave (
    input  addr1_o, addr2_o, read_en1_o, read_en2_o, write_en1_o, write_en2_o,
    input  w_data1_o, w_data2_o, reg_read1_o, reg_read2_o, reg_write1_o, reg_write2_o,
    input  reg_set1_idx_o, reg_set2_idx_o, reg_data1_o, reg_data2_o,
    output r_data1_i, r_data2_i, read_ack1_i, read_ack2_i, write_ack1_i, write_ack2_i,
    output reg_data1_i, reg_data2_i, reg_ack1_i, reg_ack2_i
  );
endinterface

// File: rtl/main_mem_fu.sv
// Purpose: moves two 32-bit words between main memory and the tile register file (write op: regs->mem, read op: mem->regs).
// Latency: three phases of (request + ack wait + one gap cycle); with zero-wait acks about 7 cycles from start to IDLE.
// Backpressure: every request is a registered level held until its lane's ack; a phase waits for both lanes, no timeout.
// Ports: clk_i/reset_i (sync, active high), on_off_i start pulse, config_i op config
//   ([3] is_read, [6:4] addr set, [9:7] data set 1, [12:10] data set 2, sets 1-based), bus = master side of main_mem_fu_if.
module main_mem_fu #(
  parameter int data_width        = 32,
  parameter int addr_size         = 16,
  parameter int num_reg_sets      = 6,
  parameter int reg_set_idx_width = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 on_off_i,
  input  logic [addr_size-1:0] config_i,
  main_mem_fu_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_ADDR = 3'd1,
    GAP        = 3'd2,
    FETCH_DATA = 3'd3,
    MEM_WRITE  = 3'd4,
    MEM_READ   = 3'd5,
    REG_WRITE  = 3'd6
  } state_t;

  localparam logic [2:0] SET_MAX = 3'(num_reg_sets);

  state_t     current_state;
  state_t     after_gap;      // phase to enter once the gap cycle is over
  logic       is_read_q;
  logic [2:0] d1_q, d2_q;
  logic       done1, done2;   // lane finished within the current phase

  function automatic logic set_ok(input logic [2:0] f);
    return (f != 3'd0) && (f <= SET_MAX);
  endfunction

  function automatic logic [reg_set_idx_width-1:0] set_idx(input logic [2:0] f);
    logic [2:0] z;
    z = f - 3'd1;
    return reg_set_idx_width'(z);
  endfunction

  logic [2:0] cfg_a, cfg_d1, cfg_d2;
  logic       cfg_valid;
  logic       unused_cfg;

  assign cfg_a      = config_i[6:4];
  assign cfg_d1     = config_i[9:7];
  assign cfg_d2     = config_i[12:10];
  assign cfg_valid  = set_ok(cfg_a) && set_ok(cfg_d1) && set_ok(cfg_d2);
  assign unused_cfg = ^{config_i[2:0], config_i[addr_size-1:13]};

  // An ack only counts while that lane has a request up; this is what makes
  // acks in IDLE, in GAP, on an idle lane or lingering after a drop harmless.
  logic hit1, hit2, fin1, fin2;

  assign hit1 = (bus.reg_read1_o  & bus.reg_ack1_i)  | (bus.reg_write1_o & bus.reg_ack1_i) |
                (bus.read_en1_o   & bus.read_ack1_i) | (bus.write_en1_o  & bus.write_ack1_i);
  assign hit2 = (bus.reg_read2_o  & bus.reg_ack2_i)  | (bus.reg_write2_o & bus.reg_ack2_i) |
                (bus.read_en2_o   & bus.read_ack2_i) | (bus.write_en2_o  & bus.write_ack2_i);
  assign fin1 = done1 | hit1;
  assign fin2 = done2 | hit2;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      current_state      <= IDLE;
      after_gap          <= IDLE;
      is_read_q          <= 1'b0;
      d1_q               <= '0;
      d2_q               <= '0;
      done1              <= 1'b0;
      done2              <= 1'b0;
      bus.addr1_o        <= '0;
      bus.addr2_o        <= '0;
      bus.read_en1_o     <= 1'b0;
      bus.read_en2_o     <= 1'b0;
      bus.write_en1_o    <= 1'b0;
      bus.write_en2_o    <= 1'b0;
      bus.w_data1_o      <= '0;
      bus.w_data2_o      <= '0;
      bus.reg_read1_o    <= 1'b0;
      bus.reg_read2_o    <= 1'b0;
      bus.reg_write1_o   <= 1'b0;
      bus.reg_write2_o   <= 1'b0;
      bus.reg_set1_idx_o <= '0;
      bus.reg_set2_idx_o <= '0;
      bus.reg_data1_o    <= '0;
      bus.reg_data2_o    <= '0;
    end else begin
      case (current_state)
        IDLE: begin
          if (on_off_i && cfg_valid) begin
            is_read_q          <= config_i[3];
            d1_q               <= cfg_d1;
            d2_q               <= cfg_d2;
            bus.reg_read1_o    <= 1'b1;
            bus.reg_set1_idx_o <= set_idx(cfg_a);
            done1              <= 1'b0;
            done2              <= 1'b1;   // address fetch uses lane 1 only
            current_state      <= FETCH_ADDR;
          end
        end

        GAP: begin
          current_state <= after_gap;
          done1         <= 1'b0;
          done2         <= 1'b0;
          case (after_gap)
            FETCH_DATA: begin
              bus.reg_read1_o    <= 1'b1;
              bus.reg_read2_o    <= 1'b1;
              bus.reg_set1_idx_o <= set_idx(d1_q);
              bus.reg_set2_idx_o <= set_idx(d2_q);
            end
            MEM_WRITE: begin
              bus.write_en1_o <= 1'b1;
              bus.write_en2_o <= 1'b1;
            end
            MEM_READ: begin
              bus.read_en1_o <= 1'b1;
              bus.read_en2_o <= 1'b1;
            end
            REG_WRITE: begin
              bus.reg_write1_o   <= 1'b1;
              bus.reg_write2_o   <= 1'b1;
              bus.reg_set1_idx_o <= set_idx(d1_q);
              bus.reg_set2_idx_o <= set_idx(d2_q);
            end
            default: ;
          endcase
        end

        default: begin
          // Active phase: each lane drops its request the cycle after its ack.
          done1 <= fin1;
          done2 <= fin2;
          if (hit1) begin
            bus.reg_read1_o  <= 1'b0;
            bus.reg_write1_o <= 1'b0;
            bus.read_en1_o   <= 1'b0;
            bus.write_en1_o  <= 1'b0;
          end
          if (hit2) begin
            bus.reg_read2_o  <= 1'b0;
            bus.reg_write2_o <= 1'b0;
            bus.read_en2_o   <= 1'b0;
            bus.write_en2_o  <= 1'b0;
          end

          case (current_state)
            FETCH_ADDR: begin
              if (hit1) begin
                bus.addr1_o <= bus.reg_data1_i[addr_size-1:0];
                bus.addr2_o <= bus.reg_data1_i[2*addr_size-1:addr_size];
              end
            end
            FETCH_DATA: begin
              if (hit1) bus.w_data1_o <= bus.reg_data1_i;
              if (hit2) bus.w_data2_o <= bus.reg_data2_i;
            end
            MEM_READ: begin
              if (hit1) bus.reg_data1_o <= bus.r_data1_i;
              if (hit2) bus.reg_data2_o <= bus.r_data2_i;
            end
            default: ;
          endcase

          if (fin1 && fin2) begin
            current_state <= GAP;
            case (current_state)
              FETCH_ADDR: after_gap <= is_read_q ? MEM_READ : FETCH_DATA;
              FETCH_DATA: after_gap <= MEM_WRITE;
              MEM_READ:   after_gap <= REG_WRITE;
              default:    after_gap <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_fu.sv
// Directed bench for main_mem_fu: a single process drives stimulus and models
// main memory plus the register file, with per-lane ack delay and lingering acks.
module tb_main_mem_fu;

  logic        clk;
  logic        reset;
  logic        on_off;
  logic [15:0] cfg;

  main_mem_fu_if bus ();

  main_mem_fu dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .on_off_i (on_off),
    .config_i (cfg),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // lane-indexed views of the bus
  logic [2:1]  rr, rw, re, we, rack, mrack, wack;
  logic [31:0] rdin [1:2];
  logic [31:0] mdin [1:2];
  logic [31:0] wd   [1:2];
  logic [31:0] rdo  [1:2];
  logic [15:0] addr [1:2];
  logic [2:0]  idx  [1:2];

  assign rr = {bus.reg_read2_o,  bus.reg_read1_o};
  assign rw = {bus.reg_write2_o, bus.reg_write1_o};
  assign re = {bus.read_en2_o,   bus.read_en1_o};
  assign we = {bus.write_en2_o,  bus.write_en1_o};
  assign bus.reg_ack1_i   = rack[1];
  assign bus.reg_ack2_i   = rack[2];
  assign bus.read_ack1_i  = mrack[1];
  assign bus.read_ack2_i  = mrack[2];
  assign bus.write_ack1_i = wack[1];
  assign bus.write_ack2_i = wack[2];
  assign bus.reg_data1_i  = rdin[1];
  assign bus.reg_data2_i  = rdin[2];
  assign bus.r_data1_i    = mdin[1];
  assign bus.r_data2_i    = mdin[2];
  assign wd[1]   = bus.w_data1_o;
  assign wd[2]   = bus.w_data2_o;
  assign rdo[1]  = bus.reg_data1_o;
  assign rdo[2]  = bus.reg_data2_o;
  assign addr[1] = bus.addr1_o;
  assign addr[2] = bus.addr2_o;
  assign idx[1]  = bus.reg_set1_idx_o;
  assign idx[2]  = bus.reg_set2_idx_o;

  logic [31:0] regs [0:7];
  logic [31:0] mem  [0:65535];
  int          st   [1:2];
  int          cnt  [1:2];
  int          dly  [1:2];
  bit          linger;

  int          n_checks, n_errors;
  int          gaps, fd_ticks;
  logic [7:0]  mask;
  bit          split;
  logic [2:0]  prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] state();
    return dut.current_state;
  endfunction

  function automatic logic [7:0] reqs();
    return {rr, rw, re, we};
  endfunction

  // Slave model: st 0 idle, 1 counting delay, 2 ack high, 3 ack lingering.
  task automatic respond();
    for (int l = 1; l <= 2; l++) begin
      logic req;
      req = rr[l] | rw[l] | re[l] | we[l];
      case (st[l])
        0: if (req) begin cnt[l] = dly[l]; st[l] = 1; end
        2: begin
          if (linger) st[l] = 3;
          else begin rack[l] = 1'b0; mrack[l] = 1'b0; wack[l] = 1'b0; st[l] = 0; end
        end
        3: begin rack[l] = 1'b0; mrack[l] = 1'b0; wack[l] = 1'b0; st[l] = 0; end
        default: ;
      endcase
      if (st[l] == 1) begin
        if (!req || reset) st[l] = 0;
        else if (cnt[l] == 0) begin
          if (rr[l]) begin rdin[l] = regs[idx[l]]; rack[l] = 1'b1; end
          if (rw[l]) begin regs[idx[l]] = rdo[l]; rack[l] = 1'b1; end
          if (re[l]) begin mdin[l] = mem[addr[l]]; mrack[l] = 1'b1; end
          if (we[l]) begin mem[addr[l]] = wd[l]; wack[l] = 1'b1; end
          st[l] = 2;
        end else cnt[l]--;
      end
    end
  endtask

  task automatic note();
    logic [2:0] s;
    s = state();
    mask = mask | (8'd1 << s);
    if (s == 3'd2 && prev != 3'd2) gaps++;
    if (s == 3'd3) fd_ticks++;
    if (s == 3'd3 && !rr[1] && rr[2]) split = 1'b1;
    prev = s;
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
    note();
  endtask

  task automatic start_op(input logic [15:0] c);
    mask = '0; gaps = 0; fd_ticks = 0; split = 1'b0; prev = 3'd0;
    cfg = c;
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    int n;
    n = 0;
    while (state() != target && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 32'(state()), 32'(target));
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_addr"},  {bus.addr2_o, bus.addr1_o}, 32'h0);
    chk({t, "_req"},   32'(reqs()), 32'h0);
    chk({t, "_wd1"},   bus.w_data1_o, 32'h0);
    chk({t, "_wd2"},   bus.w_data2_o, 32'h0);
    chk({t, "_rdo1"},  bus.reg_data1_o, 32'h0);
    chk({t, "_rdo2"},  bus.reg_data2_o, 32'h0);
    chk({t, "_idx"},   32'({bus.reg_set2_idx_o, bus.reg_set1_idx_o}), 32'h0);
    chk({t, "_state"}, 32'(state()), 32'h0);
  endtask

  task automatic idle_watch(input string t, input int cycles);
    logic [7:0] any;
    logic       moved;
    any = '0;
    moved = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      any = any | reqs();
      if (state() != 3'd0) moved = 1'b1;
    end
    chk({t, "_req"}, 32'(any), 32'h0);
    chk({t, "_moved"}, 32'(moved), 32'h0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; on_off = 1'b0; cfg = '0; linger = 1'b0;
    rack = '0; mrack = '0; wack = '0;
    for (int l = 1; l <= 2; l++) begin
      rdin[l] = '0; mdin[l] = '0; st[l] = 0; cnt[l] = 0; dly[l] = 0;
    end
    for (int i = 0; i < 8; i++) regs[i] = '0;
    mask = '0; gaps = 0; fd_ticks = 0; split = 1'b0; prev = 3'd0;

    // reset held two cycles
    tick(); tick();
    chk_zero("rst");
    reset = 1'b0;
    tick();

    // write op: A=1, D1=2, D2=3
    regs[0] = {16'h1004, 16'h1000};
    regs[1] = 32'hAABBCCDD;
    regs[2] = 32'hEEFF1122;
    start_op(16'h0D10);
    wait_state("wr", 3'd0);
    chk("wr_mem1000", mem[16'h1000], 32'hAABBCCDD);
    chk("wr_mem1004", mem[16'h1004], 32'hEEFF1122);
    chk("wr_gaps", gaps, 3);
    chk("wr_mask", 32'(mask), 32'h1F);
    chk("wr_req_idle", 32'(reqs()), 32'h0);
    chk("wr_addr_hold", {bus.addr2_o, bus.addr1_o}, 32'h10041000);
    chk("wr_wdata_hold", bus.w_data1_o, 32'hAABBCCDD);

    // read op: A=4, D1=5, D2=6
    regs[3] = {16'h2008, 16'h2000};
    mem[16'h2000] = 32'h11223344;
    mem[16'h2008] = 32'h55667788;
    start_op(16'h1AC8);
    wait_state("rd", 3'd0);
    chk("rd_set4", regs[4], 32'h11223344);
    chk("rd_set5", regs[5], 32'h55667788);
    chk("rd_gaps", gaps, 3);
    chk("rd_mask", 32'(mask), 32'h67);
    chk("rd_rdo_hold", bus.reg_data1_o, 32'h11223344);

    // lane 2 acks five cycles after lane 1
    dly[2] = 5;
    regs[0] = {16'h3004, 16'h3000};
    regs[1] = 32'h12345678;
    regs[2] = 32'h9ABCDEF0;
    start_op(16'h0D10);
    wait_state("skew", 3'd0);
    chk("skew_mem3000", mem[16'h3000], 32'h12345678);
    chk("skew_mem3004", mem[16'h3004], 32'h9ABCDEF0);
    chk("skew_fd_ticks", fd_ticks, 6);
    chk("skew_lane1_drop", 32'(split), 32'h1);
    chk("skew_gaps", gaps, 3);
    dly[2] = 0;

    // acks held one cycle past the request drop
    linger = 1'b1;
    regs[3] = {16'h5008, 16'h5000};
    regs[4] = '0;
    regs[5] = '0;
    mem[16'h5000] = 32'hCAFEBABE;
    mem[16'h5008] = 32'hDEADBEEF;
    start_op(16'h1AC8);
    wait_state("lng", 3'd0);
    chk("lng_set4", regs[4], 32'hCAFEBABE);
    chk("lng_set5", regs[5], 32'hDEADBEEF);
    chk("lng_gaps", gaps, 3);
    chk("lng_mask", 32'(mask), 32'h67);
    tick(); tick();
    linger = 1'b0;

    // invalid configs: A=0, then D2=7
    start_op(16'h0D00);
    idle_watch("inv_a0", 5);
    start_op(16'h1D10);
    idle_watch("inv_d7", 5);

    // start pulse while busy in MEM_WRITE
    regs[0] = {16'h4004, 16'h4000};
    regs[1] = 32'h01020304;
    regs[2] = 32'h05060708;
    start_op(16'h0D10);
    wait_state("busy_mw", 3'd4);
    cfg = 16'h1AC8;
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    cfg = '0;
    wait_state("busy", 3'd0);
    idle_watch("busy_after", 4);
    chk("busy_mem4000", mem[16'h4000], 32'h01020304);
    chk("busy_mem4004", mem[16'h4004], 32'h05060708);

    // reset in the middle of FETCH_DATA
    dly[1] = 10;
    dly[2] = 10;
    regs[0] = {16'h6004, 16'h6000};
    start_op(16'h0D10);
    wait_state("rstmid_fd", 3'd3);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_zero("rstmid");
    dly[1] = 0;
    dly[2] = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
